// File: rtl/button_event_ctrl_if.sv
// Event stream carrying one button event at a time from the controller to its consumer.
interface button_event_ctrl_if #(
  parameter int N_BTN = 4
);
  localparam int ID_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_repeat;
  logic            evt_ready;

  modport master (output evt_valid, output evt_id, output evt_repeat, input evt_ready);
  modport slave  (input evt_valid, input evt_id, input evt_repeat, output evt_ready);
endinterface

// File: rtl/button_event_ctrl.sv
// Turns debounced button levels into a single stream of press / auto-repeat events,
// round-robin arbitrated, with one pending request slot per button.
module button_event_ctrl #(
  parameter int N_BTN        = 4,
  parameter int HOLD_TICKS   = 50,
  parameter int REPEAT_TICKS = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [N_BTN-1:0]   btn_db,
  button_event_ctrl_if.master evt,
  output logic               overrun
);
  localparam int ID_W   = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int CNT_W  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam int RELOAD = (HOLD_TICKS > REPEAT_TICKS) ? (HOLD_TICKS - REPEAT_TICKS) : 0;

  logic [N_BTN-1:0] prev, pend, pend_rep;
  logic [N_BTN-1:0] press, rep_hit, req, ovr_now;
  logic [N_BTN-1:0] pend_nxt, pend_rep_nxt;
  logic [CNT_W-1:0] cnt     [N_BTN];
  logic [CNT_W-1:0] cnt_nxt [N_BTN];
  logic [ID_W-1:0]  rr, rr_nxt, grant_id;
  logic             grant_any, load_ok;
  int               idx;

  // A press and a tick in the same cycle: the press clears the counter and the tick is lost.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      press[i]   = btn_db[i] & ~prev[i];
      rep_hit[i] = 1'b0;
      cnt_nxt[i] = cnt[i];
      if (!btn_db[i] || press[i]) begin
        cnt_nxt[i] = '0;
      end else if (tick && HOLD_TICKS != 0) begin
        if (int'(cnt[i]) + 1 == HOLD_TICKS) begin
          rep_hit[i] = 1'b1;
          cnt_nxt[i] = CNT_W'(RELOAD);
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
    req = press | rep_hit;
  end

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = int'(rr) + k;
      if (idx >= N_BTN) idx = idx - N_BTN;
      if (!grant_any && pend[idx]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
    load_ok = !evt.evt_valid || evt.evt_ready;
    rr_nxt  = (int'(grant_id) == N_BTN - 1) ? '0 : grant_id + ID_W'(1);
  end

  // A slot being handed to the output register this cycle is free for a new request.
  always_comb begin
    pend_nxt     = pend;
    pend_rep_nxt = pend_rep;
    ovr_now      = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (req[i]) begin
        if (pend[i] && !(load_ok && grant_any && grant_id == ID_W'(i))) begin
          ovr_now[i] = 1'b1;
        end else begin
          pend_nxt[i]     = 1'b1;
          pend_rep_nxt[i] = rep_hit[i];
        end
      end else if (load_ok && grant_any && grant_id == ID_W'(i)) begin
        pend_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev           <= '1;
      pend           <= '0;
      pend_rep       <= '0;
      rr             <= '0;
      overrun        <= 1'b0;
      evt.evt_valid  <= 1'b0;
      evt.evt_id     <= '0;
      evt.evt_repeat <= 1'b0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      prev     <= btn_db;
      pend     <= pend_nxt;
      pend_rep <= pend_rep_nxt;
      overrun  <= |ovr_now;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= cnt_nxt[i];
      if (load_ok) begin
        if (grant_any) begin
          evt.evt_valid  <= 1'b1;
          evt.evt_id     <= grant_id;
          evt.evt_repeat <= pend_rep[grant_id];
          rr             <= rr_nxt;
        end else begin
          evt.evt_valid  <= 1'b0;
        end
      end
    end
  end
endmodule
